// File: rtl/ifu_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc_fetch
// Description : Instruction-fetch front end. Holds the fetch PC, issues one
//               outstanding request at a time to instruction memory, captures
//               the returned word into a single-entry instruction register and
//               redirects (with wrong-path squash) on a taken jump.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // Redirect from the execute-stage branch/jump resolver
  input  logic        i_jump_en,
  input  logic [31:0] i_jump_addr,
  // Request channel to instruction memory
  output logic        o_fetch_req_valid,
  input  logic        i_fetch_req_ready,
  output logic [31:0] o_fetch_addr,
  // Response channel from instruction memory
  input  logic        i_fetch_rsp_valid,
  input  logic [31:0] i_fetch_rsp_data,
  // Instruction register towards decode
  output logic        o_ir_valid,
  output logic [31:0] o_ir,
  output logic [31:0] o_ir_pc,
  input  logic        i_ir_ready,
  // Squash pulse for younger in-flight instructions
  output logic        o_flush
);

  // REQ : request presented to memory
  // WAIT: one response outstanding
  // HOLD: IR full, waiting for decode to take it
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic        r_out_of_reset;
  logic        r_ir_valid;
  logic        w_ir_valid_nxt;
  logic [31:0] r_ir;
  logic [31:0] w_ir_nxt;
  logic [31:0] r_ir_pc;
  logic [31:0] w_ir_pc_nxt;
  logic        r_flush;
  logic        w_flush_nxt;

  logic        w_req_valid;
  logic        w_req_fire;
  logic [31:0] w_jump_pc;
  logic [31:0] w_pc_inc;
  logic        w_unused_jump_lsb;

  // The request is held off for one cycle after reset release so that the
  // first request never coincides with the reset-release edge.
  assign w_req_valid = r_out_of_reset && (r_state == ST_REQ);
  assign w_req_fire  = w_req_valid && i_fetch_req_ready;

  // Targets are forced to word alignment; the low address bits are ignored.
  assign w_jump_pc         = {i_jump_addr[31:2], 2'b00};
  assign w_unused_jump_lsb = |i_jump_addr[1:0];

  // Sequential increment; 32'hFFFF_FFFC naturally wraps to zero.
  assign w_pc_inc = r_pc + 32'd4;

  assign o_fetch_req_valid = w_req_valid;
  assign o_fetch_addr      = r_pc;
  assign o_ir_valid        = r_ir_valid;
  assign o_ir              = r_ir;
  assign o_ir_pc           = r_ir_pc;
  assign o_flush           = r_flush;

  // Marks the first cycle after reset release and stays set afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_of_reset <= 1'b0;
    end else begin
      r_out_of_reset <= 1'b1;
    end
  end

  // State, PC, drop flag, IR and flush registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_ir_valid <= 1'b0;
      r_ir       <= NOP_INSN;
      r_ir_pc    <= RESET_PC;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  // Next-state logic; a redirect takes precedence over all normal progress.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_ir_valid_nxt = r_ir_valid;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_flush_nxt    = 1'b0;

    if (i_jump_en) begin
      // Redirect: move the PC, kill the IR and flag downstream to squash.
      w_pc_nxt       = w_jump_pc;
      w_ir_valid_nxt = 1'b0;
      w_ir_nxt       = NOP_INSN;
      w_flush_nxt    = 1'b1;
      case (r_state)
        ST_REQ: begin
          if (w_req_fire) begin
            // Old-address request was accepted anyway; its data must die.
            w_state_nxt = ST_WAIT;
            w_drop_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (i_fetch_rsp_valid) begin
            // Wrong-path data arrives right now: discard it and refetch.
            w_state_nxt = ST_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end
        ST_HOLD: begin
          // A same-cycle consume is overridden: the IR is killed.
          w_state_nxt = ST_REQ;
        end
        default: begin
          w_state_nxt = ST_REQ;
          w_drop_nxt  = 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_req_fire) begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_fetch_rsp_valid) begin
            if (r_drop) begin
              // Response to a squashed request: swallow it.
              w_drop_nxt  = 1'b0;
              w_state_nxt = ST_REQ;
            end else begin
              w_ir_nxt       = i_fetch_rsp_data;
              w_ir_pc_nxt    = r_pc;
              w_ir_valid_nxt = 1'b1;
              w_pc_nxt       = w_pc_inc;
              w_state_nxt    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_ir_ready) begin
            w_ir_valid_nxt = 1'b0;
            w_ir_nxt       = NOP_INSN;
            w_state_nxt    = ST_REQ;
          end
        end
        default: begin
          w_state_nxt = ST_REQ;
          w_drop_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_pc_fetch
// Description : Self-checking bench for ifu_pc_fetch with a latency-programmable
//               instruction-memory model and an expected-IR scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_pc_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] fetch_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data  = 32'h0;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic        flush;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        prev_v = 1'b0;
  logic [31:0] sb_q[$];

  ifu_pc_fetch #(
    .RESET_PC (RST_PC),
    .NOP_INSN (NOP)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_jump_en         (jump_en),
    .i_jump_addr       (jump_addr),
    .o_fetch_req_valid (req_valid),
    .i_fetch_req_ready (req_ready),
    .o_fetch_addr      (fetch_addr),
    .i_fetch_rsp_valid (rsp_valid),
    .i_fetch_rsp_data  (rsp_data),
    .o_ir_valid        (ir_valid),
    .o_ir              (ir),
    .o_ir_pc           (ir_pc),
    .i_ir_ready        (ir_ready),
    .o_flush           (flush)
  );

  always #5 clk = ~clk;

  // Memory contents as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!req_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_req"}, {31'b0, req_valid}, 32'd1);
  endtask

  task automatic wait_ir(input string tag);
    int k = 0;
    while (!ir_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, {31'b0, ir_valid}, 32'd1);
  endtask

  // Memory model: accepts on handshake, answers 'lat' cycles later
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      pend_cnt  = 0;
      rsp_valid = 1'b0;
    end else begin
      rsp_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_word(pend_addr);
        end
      end
      if (req_valid && req_ready) begin
        pend_addr = fetch_addr;
        pend_cnt  = lat;
      end
      if (rsp_valid) check("rsp_only_in_wait", {30'b0, req_valid, ir_valid}, 32'd0);
    end
  end

  // Scoreboard: each newly valid IR must match the oldest expected fetch
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (ir_valid && !prev_v) begin
        n_tests++;
        assert (sb_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed pc %08h expected no IR", ir_pc);
        end
        if (sb_q.size() != 0) begin
          logic [31:0] e;
          e = sb_q.pop_front();
          check("sb_pc", ir_pc, e);
          check("sb_data", ir, mem_word(e));
        end
      end
      prev_v = ir_valid;
    end
  end

  initial begin
    rst = 1'b1; jump_en = 1'b0; jump_addr = 32'h0; req_ready = 1'b1; ir_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_ir", ir, NOP);
    check("rst_ir_pc", ir_pc, RST_PC);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_addr", fetch_addr, RST_PC);

    // First fetch after reset release, wrap-around of the PC
    sb_q.push_back(RST_PC);
    rst = 1'b0;
    @(negedge clk);
    check("c1_req_valid", {31'b0, req_valid}, 32'd1);
    check("c1_addr", fetch_addr, RST_PC);
    @(negedge clk);
    check("c2_req_valid", {31'b0, req_valid}, 32'd0);
    check("c2_ir_valid", {31'b0, ir_valid}, 32'd0);
    @(negedge clk);
    check("c3_ir_valid", {31'b0, ir_valid}, 32'd1);
    ir_ready = 1'b1;
    @(negedge clk);
    check("c4_req_valid", {31'b0, req_valid}, 32'd1);
    check("c4_wrap_addr", fetch_addr, 32'h0);
    check("c4_ir_valid", {31'b0, ir_valid}, 32'd0);
    sb_q.push_back(32'h0);
    wait_ir("ir0");

    wait_req("f4");
    check("f4_addr", fetch_addr, 32'h4);
    sb_q.push_back(32'h4);
    wait_ir("ir4");

    // Request backpressure
    wait_req("bp");
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, req_valid}, 32'd1);
      check("bp_addr", fetch_addr, 32'h8);
    end
    req_ready = 1'b1;
    sb_q.push_back(32'h8);
    @(negedge clk);
    check("bp_wait", {31'b0, req_valid}, 32'd0);
    wait_ir("ir8");

    // Jump while WAIT, one cycle before the response
    wait_req("jw");
    check("jw_addr0", fetch_addr, 32'hC);
    lat = 2;
    @(negedge clk);
    lat = 1; jump_en = 1'b1; jump_addr = 32'h100;
    @(negedge clk);
    jump_en = 1'b0;
    check("jw_flush", {31'b0, flush}, 32'd1);
    check("jw_req_wait", {31'b0, req_valid}, 32'd0);
    check("jw_addr", fetch_addr, 32'h100);
    check("jw_ir_valid", {31'b0, ir_valid}, 32'd0);
    @(negedge clk);
    check("jw_flush_once", {31'b0, flush}, 32'd0);
    check("jw_req", {31'b0, req_valid}, 32'd1);
    check("jw_addr2", fetch_addr, 32'h100);
    sb_q.push_back(32'h100);
    wait_ir("ir100");

    // Jump coincident with the response
    wait_req("jc");
    check("jc_addr0", fetch_addr, 32'h104);
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 32'h203;
    @(negedge clk);
    jump_en = 1'b0;
    check("jc_flush", {31'b0, flush}, 32'd1);
    check("jc_req", {31'b0, req_valid}, 32'd1);
    check("jc_addr", fetch_addr, 32'h200);
    check("jc_ir_valid", {31'b0, ir_valid}, 32'd0);
    sb_q.push_back(32'h200);
    wait_ir("ir200");

    // Jump in REQ with a same-cycle handshake
    wait_req("jr");
    check("jr_addr0", fetch_addr, 32'h204);
    jump_en = 1'b1; jump_addr = 32'h40; ir_ready = 1'b0;
    @(negedge clk);
    jump_en = 1'b0;
    check("jr_flush", {31'b0, flush}, 32'd1);
    check("jr_req_wait", {31'b0, req_valid}, 32'd0);
    check("jr_addr", fetch_addr, 32'h40);
    @(negedge clk);
    check("jr_req", {31'b0, req_valid}, 32'd1);
    check("jr_addr2", fetch_addr, 32'h40);
    sb_q.push_back(32'h40);
    wait_ir("ir40");

    // Jump while HOLD with decode stalled
    @(negedge clk);
    check("hold_valid", {31'b0, ir_valid}, 32'd1);
    check("hold_pc", ir_pc, 32'h40);
    jump_en = 1'b1; jump_addr = 32'h300;
    @(negedge clk);
    jump_en = 1'b0;
    check("jh_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("jh_ir", ir, NOP);
    check("jh_flush", {31'b0, flush}, 32'd1);
    check("jh_req", {31'b0, req_valid}, 32'd1);
    check("jh_addr", fetch_addr, 32'h300);
    sb_q.push_back(32'h300);
    ir_ready = 1'b1;
    wait_ir("ir300");

    // Back-to-back jumps: last target wins
    wait_req("bb");
    check("bb_addr0", fetch_addr, 32'h304);
    req_ready = 1'b0; jump_en = 1'b1; jump_addr = 32'h500;
    @(negedge clk);
    jump_addr = 32'h600;
    check("bb_flush1", {31'b0, flush}, 32'd1);
    check("bb_addr1", fetch_addr, 32'h500);
    @(negedge clk);
    jump_en = 1'b0;
    check("bb_flush2", {31'b0, flush}, 32'd1);
    check("bb_addr2", fetch_addr, 32'h600);
    @(negedge clk);
    check("bb_flush3", {31'b0, flush}, 32'd0);
    check("bb_req", {31'b0, req_valid}, 32'd1);
    check("bb_addr3", fetch_addr, 32'h600);
    req_ready = 1'b1;
    sb_q.push_back(32'h600);
    wait_ir("ir600");

    // Async reset mid-WAIT while a drop is pending
    wait_req("rw");
    check("rw_addr0", fetch_addr, 32'h604);
    lat = 3;
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 32'h700;
    @(negedge clk);
    jump_en = 1'b0; lat = 1;
    #3 rst = 1'b1;
    #1;
    check("rw_req_valid", {31'b0, req_valid}, 32'd0);
    check("rw_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rw_ir", ir, NOP);
    check("rw_ir_pc", ir_pc, RST_PC);
    check("rw_addr", fetch_addr, RST_PC);
    check("rw_flush", {31'b0, flush}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(RST_PC);
    @(negedge clk);
    check("rr_req", {31'b0, req_valid}, 32'd1);
    check("rr_addr", fetch_addr, RST_PC);
    wait_ir("ir_rst");
    @(negedge clk);
    check("rr_wrap_addr", fetch_addr, 32'h0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_pc_fetch.md
Name: ifu_pc_fetch

Overview:
- Instruction-fetch front end. Holds the architectural fetch PC and issues one-outstanding fetch requests to instruction memory.
- Captures the returned word into a single-entry instruction register (IR) that feeds decode.
- Redirects on the taken-jump indication produced by the execute-stage branch/jump resolver, squashing any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, value driven on o_ir while empty or flushed (addi x0,x0,0).

Ports:
- i_clk  input  1  core clock, all state on rising edge
- i_rst  input  1  asynchronous active-high reset
- i_jump_en  input  1  taken branch/jump from execute stage, single-cycle qualifier
- i_jump_addr  input  32  redirect target, valid when i_jump_en=1
- o_fetch_req_valid  output  1  fetch request valid to instruction memory
- i_fetch_req_ready  input  1  instruction memory accepts request
- o_fetch_addr  output  32  fetch address, word aligned
- i_fetch_rsp_valid  input  1  read data returned, one cycle pulse per accepted request
- i_fetch_rsp_data  input  32  instruction word
- o_ir_valid  output  1  IR holds a valid instruction
- o_ir  output  32  instruction to decode
- o_ir_pc  output  32  PC of o_ir
- i_ir_ready  input  1  decode consumes IR this cycle
- o_flush  output  1  registered one-cycle pulse; downstream kills younger in-flight instructions

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=REQ, drop=0, o_fetch_req_valid=0, o_ir_valid=0, o_ir=NOP_INSN, o_ir_pc=RESET_PC, o_flush=0.
  - o_fetch_req_valid is gated by a registered "out_of_reset" bit, so the first request appears in the cycle after reset release.
- o_fetch_addr = pc at all times. pc updates only as listed below.
- State REQ: o_fetch_req_valid=1.
  - Handshake (valid&ready) -> WAIT.
  - Without handshake, addr/valid stay stable except on redirect.
- State WAIT: o_fetch_req_valid=0. Exactly one response is outstanding.
  - On i_fetch_rsp_valid with drop=0: o_ir<=data, o_ir_pc<=pc, o_ir_valid<=1, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) -> HOLD.
  - On i_fetch_rsp_valid with drop=1: discard data, drop<=0 -> REQ.
- State HOLD: o_ir_valid=1, no request.
  - On i_ir_ready: o_ir_valid<=0, o_ir<=NOP_INSN -> REQ.
  - Fetch-to-IR latency: 1 cycle request + memory latency + 1 cycle capture. Throughput is at most one instruction per 3 cycles; by design, no prefetch.
- Redirect (i_jump_en=1) has highest priority in every state:
  - pc<={i_jump_addr[31:2],2'b00}.
  - o_ir_valid<=0, o_ir<=NOP_INSN.
  - o_flush<=1 for the next cycle only.
  - REQ, no handshake this cycle: stay REQ; the new address is presented next cycle.
  - REQ with handshake in the same cycle: -> WAIT, drop<=1 (the old-address response is discarded).
  - WAIT, no response this cycle: stay WAIT, drop<=1.
  - WAIT with i_fetch_rsp_valid in the same cycle: discard data, drop<=0 -> REQ.
  - HOLD: -> REQ; a same-cycle i_ir_ready is ignored, the IR is killed.
- Back-to-back i_jump_en on consecutive cycles: the last target wins; o_flush stays high one cycle after each.
- i_fetch_rsp_valid outside WAIT is a protocol violation. It is ignored, and the bench asserts it never occurs.
- Reset mid-WAIT: state returns to REQ with drop=0. The memory is reset by the same i_rst, so no stale response exists.

Test Plan:
- Reset release, memory ready=1, 1-cycle response: fetch_addr 0x0 accepted cycle 1, IR=mem[0] with o_ir_pc=0x0 valid cycle 3. With i_ir_ready=1, next request issues with addr 0x4.
- Request backpressure: ready=0 for 5 cycles -> req_valid and addr=0x8 held stable. Ready=1 -> handshake, WAIT.
- Jump while WAIT: i_jump_en with addr 0x100 one cycle before response -> response dropped, o_ir_valid stays 0, o_flush pulses once, next request addr=0x100, IR=mem[0x100] with o_ir_pc=0x100.
- Jump coincident with response: rsp_valid and i_jump_en (0x203) in the same cycle -> data discarded, next request addr=0x200, no stale IR.
- Jump while HOLD with i_ir_ready=0 (IR pc 0x40) -> o_ir_valid drops next cycle, o_ir=0x00000013, next fetch at the jump target.
- Wrap-around: RESET_PC=32'hFFFF_FFFC -> first IR pc 0xFFFFFFFC, next fetch addr 0x00000000. Async reset asserted mid-WAIT -> all outputs return to reset values immediately.
